// File: rtl/frame_tx.sv
// ----------------------------------------------------------------------------
// frame_tx
// Serial frame transmitter. Drives one over-the-air frame on tx_out:
//   wake-up tone (WU_LEN bit periods, 1,0,1,0...), one guard bit of 0,
//   one sync bit of 1 (its rising edge is the receiver's sync point),
//   then NUM_BYTES payload bytes, MSB first.
// Each bit period lasts DATARATE_DIV clki cycles.
//
// Optional build macro: FRAME_TX_MANCHESTER_EN
//   When defined, payload bits are Manchester coded (bit value for the first
//   half of the period, inverted for the second half). Wake-up, guard and
//   sync bits are always plain NRZ. Frame length is identical either way.
//
// Ports:
//   clki        system clock, everything on posedge
//   rst         synchronous active-high reset
//   start       frame request, only looked at while idle
//   data_in     payload byte from the upstream buffer
//   data_valid  data_in holds a valid byte
//   data_ready  one-cycle fetch strobe; a byte moves when
//               data_ready & data_valid are both high in the same cycle
//   tx_out      serial line to the modulator (registered)
//   busy        high while a frame is on the line (registered)
//   done        one-cycle pulse after the last payload bit period
//   underflow   sticky: some fetch of this frame found data_valid low
// ----------------------------------------------------------------------------
module frame_tx #(
   parameter int DATARATE_DIV = 100,
   parameter int WU_LEN       = 16,
   parameter int NUM_BYTES    = 125
) (
   input  logic       clki,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic       data_ready,
   output logic       tx_out,
   output logic       busy,
   output logic       done,
   output logic       underflow
);

   localparam int CW        = $clog2(DATARATE_DIV);
   localparam int DATA_BITS = 8 * NUM_BYTES;
   localparam int MAX_BITS  = (WU_LEN > DATA_BITS) ? WU_LEN : DATA_BITS;
   localparam int IW        = $clog2(MAX_BITS + 1);

   localparam logic [CW-1:0] CNT_LAST  = CW'(DATARATE_DIV - 1);
   localparam logic [IW-1:0] WU_LAST   = IW'(WU_LEN - 1);
   localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
   // Bit index of the first bit of the final byte; fetches stop there.
   localparam logic [IW-1:0] FETCH_LIM = IW'(DATA_BITS - 8);
`ifdef FRAME_TX_MANCHESTER_EN
   localparam logic [CW-1:0] CNT_HALF  = CW'(DATARATE_DIV / 2 - 1);
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAKEUP,
      S_GUARD,
      S_SYNC,
      S_DATA
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;          // cycle within the current bit period
   logic [IW-1:0] idx, idx_n;          // bit index within the current section
   logic [7:0]    shreg, shreg_n;      // byte on the line, current bit at [7]
   logic [7:0]    nxt_byte, nxt_byte_n;// byte fetched ahead for the next slot
   logic          tx_n, busy_n, done_n, underflow_n;
   logic          bit_end;
   logic [7:0]    fetch_byte;

   always_ff @(posedge clki) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         idx       <= '0;
         shreg     <= '0;
         nxt_byte  <= '0;
         tx_out    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         underflow <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         idx       <= idx_n;
         shreg     <= shreg_n;
         nxt_byte  <= nxt_byte_n;
         tx_out    <= tx_n;
         busy      <= busy_n;
         done      <= done_n;
         underflow <= underflow_n;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      idx_n       = idx;
      shreg_n     = shreg;
      nxt_byte_n  = nxt_byte;
      tx_n        = tx_out;
      busy_n      = busy;
      done_n      = 1'b0;
      underflow_n = underflow;
      data_ready  = 1'b0;
      bit_end     = (cnt == CNT_LAST);
      // A missing byte is replaced by zero so the frame length never changes.
      fetch_byte  = data_valid ? data_in : 8'h00;

      case (state)
         S_IDLE: begin
            tx_n   = 1'b0;
            busy_n = 1'b0;
            if (start) begin
               state_n     = S_WAKEUP;
               cnt_n       = '0;
               idx_n       = '0;
               tx_n        = 1'b1;
               busy_n      = 1'b1;
               underflow_n = 1'b0;
            end
         end

         S_WAKEUP: begin
            if (bit_end) begin
               cnt_n = '0;
               if (idx == WU_LAST) begin
                  state_n = S_GUARD;
                  idx_n   = '0;
                  tx_n    = 1'b0;
               end else begin
                  idx_n = idx + IW'(1);
                  // Tone bit k is 1 for even k; the next bit is odd iff idx is even.
                  tx_n  = idx[0];
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end

         S_GUARD: begin
            if (bit_end) begin
               cnt_n   = '0;
               state_n = S_SYNC;
               tx_n    = 1'b1;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end

         S_SYNC: begin
            if (bit_end) begin
               data_ready = 1'b1;
               if (!data_valid) underflow_n = 1'b1;
               shreg_n = fetch_byte;
               tx_n    = fetch_byte[7];
               cnt_n   = '0;
               idx_n   = '0;
               state_n = S_DATA;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end

         S_DATA: begin
            // Next byte is pulled in at the end of bit 0 of the current one,
            // leaving seven bit periods of slack before it is needed.
            if (bit_end && (idx[2:0] == 3'd0) && (idx < FETCH_LIM)) begin
               data_ready = 1'b1;
               if (!data_valid) underflow_n = 1'b1;
               nxt_byte_n = fetch_byte;
            end
            if (bit_end) begin
               cnt_n = '0;
               if (idx == DATA_LAST) begin
                  state_n = S_IDLE;
                  idx_n   = '0;
                  tx_n    = 1'b0;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
               end else begin
                  idx_n = idx + IW'(1);
                  if (idx[2:0] == 3'd7) begin
                     shreg_n = nxt_byte;
                     tx_n    = nxt_byte[7];
                  end else begin
                     shreg_n = {shreg[6:0], 1'b0};
                     tx_n    = shreg[6];
                  end
               end
            end else begin
               cnt_n = cnt + CW'(1);
`ifdef FRAME_TX_MANCHESTER_EN
               // Second half of a payload bit carries the inverted value.
               if (cnt == CNT_HALF) tx_n = ~shreg[7];
`endif
            end
         end

         default: begin
            state_n = S_IDLE;
            tx_n    = 1'b0;
            busy_n  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_frame_tx.sv
// ----------------------------------------------------------------------------
// tb_frame_tx
// Directed frame sequence with random payloads against a cycle-level
// reference built from the frame layout: a list of line bits, a list of
// fetch cycles, and the frame length formula.
// ----------------------------------------------------------------------------
module tb_frame_tx;

   localparam int DIV = 4;
   localparam int WU  = 4;
   localparam int NB  = 2;
   localparam int F   = (WU + 2 + 8 * NB) * DIV;
`ifdef FRAME_TX_MANCHESTER_EN
   localparam bit MAN = 1'b1;
`else
   localparam bit MAN = 1'b0;
`endif

   logic       clki = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       data_valid = 1'b0;
   logic       data_ready, tx_out, busy, done, underflow;

   int errors = 0;
   int checks = 0;

   logic [7:0] fb [NB];
   bit         fv [NB];

   frame_tx #(
      .DATARATE_DIV(DIV),
      .WU_LEN(WU),
      .NUM_BYTES(NB)
   ) dut (
      .clki(clki),
      .rst(rst),
      .start(start),
      .data_in(data_in),
      .data_valid(data_valid),
      .data_ready(data_ready),
      .tx_out(tx_out),
      .busy(busy),
      .done(done),
      .underflow(underflow)
   );

   // clock
   always #5 clki = ~clki;

   task automatic chk_bit(input string tag, input int c, input logic obs, input logic exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, c, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive_idle_data();
      data_in    = 8'($urandom);
      data_valid = 1'($urandom_range(0, 1));
   endtask

   // All outputs must sit at zero for n cycles.
   task automatic idle_check(input string tag, input int n);
      for (int c = 1; c <= n; c++) begin
         @(negedge clki);
         chk_bit({tag, "_tx"}, c, tx_out, 1'b0);
         chk_bit({tag, "_busy"}, c, busy, 1'b0);
         chk_bit({tag, "_done"}, c, done, 1'b0);
         chk_bit({tag, "_ready"}, c, data_ready, 1'b0);
         start = 1'b0;
         drive_idle_data();
      end
   endtask

   // One frame using fb/fv. Cycle 0 is the cycle in which start is high.
   // rst_at > 0 pulses reset during that cycle; pulse_mid raises start at
   // cycles 10 and 50; chain holds start on the done cycle; started means the
   // previous call already issued the start.
   task automatic run_frame(input string tag, input int rst_at, input bit pulse_mid,
                            input bit chain, input bit started);
      bit   expb[$];
      int   sc[$];
      int   nf;
      int   nstrobe;
      int   b, ph;
      bit   aborted;
      logic e_tx, e_busy, e_done, e_rdy, e_uf;

      for (int i = 0; i < WU; i++) expb.push_back((i % 2) == 0);
      expb.push_back(1'b0);
      expb.push_back(1'b1);
      for (int k = 0; k < NB; k++)
         for (int j = 7; j >= 0; j--) expb.push_back(fv[k] ? fb[k][j] : 1'b0);
      sc.push_back((WU + 2) * DIV);
      for (int k = 0; k < NB - 1; k++) sc.push_back((WU + 3 + 8 * k) * DIV);

      if (!started) begin
         @(negedge clki);
         start = 1'b1;
         drive_idle_data();
      end
      nf = 0;
      nstrobe = 0;
      for (int c = 1; c <= F + 1; c++) begin
         @(negedge clki);
         aborted = (rst_at > 0) && (c > rst_at);
         e_tx = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_rdy = 1'b0; e_uf = 1'b0;
         if (!aborted) begin
            e_busy = (c <= F);
            e_done = (c == F + 1);
            if (c <= F) begin
               b  = (c - 1) / DIV;
               ph = (c - 1) % DIV;
               e_tx = expb[b];
               if (MAN && (b >= WU + 2) && (ph >= DIV / 2)) e_tx = ~e_tx;
            end
            for (int j = 0; j < sc.size(); j++) begin
               if (sc[j] == c) e_rdy = 1'b1;
               if ((sc[j] < c) && !fv[j]) e_uf = 1'b1;
            end
         end
         chk_bit({tag, "_tx"}, c, tx_out, e_tx);
         chk_bit({tag, "_busy"}, c, busy, e_busy);
         chk_bit({tag, "_done"}, c, done, e_done);
         chk_bit({tag, "_ready"}, c, data_ready, e_rdy);
         chk_bit({tag, "_underflow"}, c, underflow, e_uf);
         if (data_ready) nstrobe++;

         start = (pulse_mid && (c == 10 || c == 50)) || (chain && c == F + 1);
         rst   = (c == rst_at);
         if (data_ready && nf < NB) begin
            data_in    = fb[nf];
            data_valid = fv[nf];
            nf++;
         end else begin
            drive_idle_data();
         end
      end
      if (rst_at <= 0) chk_int({tag, "_strobe_count"}, nstrobe, NB);
   endtask

   initial begin
      // reset
      rst = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clki);
         chk_bit("reset_tx", c, tx_out, 1'b0);
         chk_bit("reset_busy", c, busy, 1'b0);
         chk_bit("reset_done", c, done, 1'b0);
         chk_bit("reset_ready", c, data_ready, 1'b0);
         chk_bit("reset_underflow", c, underflow, 1'b0);
      end
      rst = 1'b0;
      idle_check("idle0", 4);

      // known pattern, all bytes valid
      fb[0] = 8'hA5; fb[1] = 8'h3C; fv[0] = 1'b1; fv[1] = 1'b1;
      run_frame("nominal", 0, 1'b0, 1'b0, 1'b0);
      idle_check("idle1", 3);

      // second fetch finds no data
      fv[1] = 1'b0;
      run_frame("underflow", 0, 1'b0, 1'b0, 1'b0);
      idle_check("idle2", 3);

      // random payload, reset mid-DATA; underflow from before must be cleared
      fb[0] = 8'($urandom); fb[1] = 8'($urandom); fv[0] = 1'b1; fv[1] = 1'b1;
      run_frame("abort", 40, 1'b0, 1'b0, 1'b0);
      idle_check("idle3", 20);

      // full frame after the abort
      fb[0] = 8'($urandom); fb[1] = 8'($urandom);
      run_frame("after_abort", 0, 1'b0, 1'b0, 1'b0);

      // stray starts mid-frame, then start held on the done cycle
      fb[0] = 8'($urandom); fb[1] = 8'($urandom);
      run_frame("ignore_start", 0, 1'b1, 1'b1, 1'b0);

      // back-to-back frame with random validity
      fb[0] = 8'($urandom); fb[1] = 8'($urandom);
      fv[0] = ($urandom_range(0, 3) != 0); fv[1] = ($urandom_range(0, 3) != 0);
      run_frame("chained", 0, 1'b0, 1'b0, 1'b1);
      idle_check("idle4", 5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute time bound so the run can never hang.
   initial begin
      #200000;
      $display("FAIL timeout reached before end of sequence");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/frame_tx.md
# frame_tx

Transmit-side counterpart of the comparator-input frame synchroniser. Emits one complete over-the-air frame on a single serial line: a wake-up tone, a guard gap, a sync rising edge, then a fixed-length payload fetched byte-by-byte from an upstream source. Bit timing derives from the system clock through a divide parameter matching the receiver's data-rate divider. The block sits between the payload buffer and the modulator/driver.

## Interface
Parameters:
- DATARATE_DIV, 100, system clocks per bit period; must be ≥2 and even.
- WU_LEN, 16, wake-up tone length in bit periods; ≥1.
- NUM_BYTES, 125, payload bytes per frame (125 = 1000 bits); ≥1.

Ports:
- clki  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- data_in  in  8  payload byte.
- data_valid  in  1  data_in holds a valid byte.
- data_ready  out  1  one-cycle byte-fetch strobe; transfer occurs when data_ready & data_valid.
- tx_out  out  1  serial line to the modulator.
- busy  out  1  high while a frame is on the line.
- done  out  1  one-cycle pulse after the last payload bit period.
- underflow  out  1  sticky: a byte fetch found data_valid low.

## Operation
- States: IDLE → WAKEUP → GUARD → SYNC → DATA → IDLE.
- IDLE: tx_out=0, busy=0. start=1 → WAKEUP next cycle, underflow cleared, bit counters zeroed.
- WAKEUP: WU_LEN bit periods, alternating 1,0,1,0… starting with 1.
- GUARD: one bit period of tx_out=0, guaranteeing a clean low before sync.
- SYNC: one bit period of tx_out=1; its rising edge is the receiver's sync point.
- DATA: NUM_BYTES×8 bit periods, each byte MSB first.
- Byte fetch: data_ready=1 on the last cycle of the SYNC period and on the last cycle of bit 0 of every byte except the final byte. If data_valid=1 that cycle, data_in loads the shift register; otherwise 0x00 loads and underflow sets.
- After the last bit period of the final byte: state→IDLE, tx_out=0, done=1 for that one cycle.
- start while not in IDLE: ignored. start on the done cycle: accepted (state is IDLE), so the next frame begins the following cycle.
- rst: all outputs 0 on the next edge, state IDLE, counters zeroed, underflow cleared. rst overrides start. Reset mid-frame aborts without done.
- Counters: bit-cycle counter ⌈log2(DATARATE_DIV)⌉ bits, wrapping at DATARATE_DIV−1; bit index wide enough for max(WU_LEN, 8×NUM_BYTES). No counter wraps silently beyond its terminal count.

## Timing
- Reset values: tx_out=0, busy=0, done=0, data_ready=0, underflow=0.
- tx_out and busy are registered. If start is sampled at cycle 0, the first wake-up bit is driven on cycles 1..DATARATE_DIV.
- Frame length F = (WU_LEN+2+8×NUM_BYTES)×DATARATE_DIV cycles. busy is high on cycles 1..F. done is high on cycle F+1.
- tx_out changes only on bit-period boundaries (NRZ), plus mid-bit transitions under Manchester.
- data_ready is never high in IDLE, WAKEUP, or GUARD.

## Configuration
- FRAME_TX_MANCHESTER_EN defined:
  - Each DATA bit is Manchester-coded: bit value for the first DATARATE_DIV/2 cycles, inverted for the second half.
  - WAKEUP, GUARD, and SYNC are unchanged.
  - Frame length is unchanged.
- Undefined: plain NRZ for all bits.

## Test plan
- DATARATE_DIV=4, WU_LEN=4, NUM_BYTES=2, bytes 0xA5 then 0x3C, data_valid=1, start at cycle 0 → per-bit tx_out 1,0,1,0 | 0 | 1 | 10100101 | 00111100. busy high on cycles 1..88, done high on cycle 89 only, underflow=0, exactly 2 data_ready strobes.
- Same setup, data_valid=0 at the second strobe → second byte transmitted as 00000000, underflow=1 from the strobe until the next start, done still on cycle 89.
- rst asserted at cycle 40 (mid-DATA) → cycle 41: tx_out=0, busy=0, no done pulse ever. A subsequent start produces a full, correct frame.
- start pulsed at cycles 10 and 50 during a frame → ignored, single done. start held high on the done cycle → new frame begins the next cycle with wake-up bit 1.
- FRAME_TX_MANCHESTER_EN, DATARATE_DIV=4, first byte 0xA5 → first data bit cycles read 1,1,0,0 and second data bit cycles read 0,0,1,1. Wake-up, guard, and sync bits are identical to NRZ.
- Default parameters (100, 16, 125), start at cycle 0 → done at cycle 101801, exactly 125 data_ready strobes.
